re_demapper: RTL and testbench

RE_DEMAPPER -- requirements
Module: re_demapper

---
 rtl/re_demapper.sv | 195 +++++++++++++++++++
 tb/tb_re_demapper.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/re_demapper.sv
// RE demapper: pulls one PUSCH allocation out of the I/Q grid and streams it as valid/ready REs.
// RE_DEMAPPER_DMRS_OUT_EN: when defined, the DMRS symbol (even subcarriers) is read and streamed too.
module re_demapper #(
    parameter int FFT_Len  = 18,
    parameter int Total_Sc = 1200
) (
    input  logic                      CLK_RE,
    input  logic                      RST_RE,
    input  logic                      Start,
    input  logic [10:0]               N_sc,
    input  logic [6:0]                N_rb,
    input  logic [3:0]                Sym_Start,
    input  logic [3:0]                Sym_End,
    output logic                      Rd_en,
    output logic [3:0]                Rd_sym,
    output logic [10:0]               Rd_addr,
    input  logic signed [FFT_Len-1:0] Rd_I,
    input  logic signed [FFT_Len-1:0] Rd_Q,
    output logic signed [FFT_Len-1:0] Data_I,
    output logic signed [FFT_Len-1:0] Data_Q,
    output logic                      Data_Valid,
    input  logic                      Data_Ready,
    output logic signed [FFT_Len-1:0] Dmrs_I,
    output logic signed [FFT_Len-1:0] Dmrs_Q,
    output logic                      Dmrs_Valid,
    output logic                      Busy,
    output logic                      Sym_Done,
    output logic                      DEM_Done,
    output logic                      Cfg_Err
);

    typedef enum logic [1:0] {IDLE, RD_DMRS, RD_DATA, DRAIN} state_t;

    localparam logic [11:0] TOTAL_SC_W = 12'(Total_Sc);

    state_t      state_q;
    logic [10:0] nsc_q;
    logic [11:0] last_q;
    logic [3:0]  send_q;
    logic [10:0] addr_q;
    logic [3:0]  sym_q;
    logic        inflight_q, infl_dmrs_q, infl_last_q;
    logic        done_q, err_q;

    logic signed [FFT_Len-1:0] fi_q [2];
    logic signed [FFT_Len-1:0] fq_q [2];
    logic                      fd_q [2];
    logic                      fl_q [2];
    logic                      wr_ptr_q, rd_ptr_q;
    logic [1:0]                occ_q, occ_d;

    logic [11:0] last_in;
    logic        cfg_bad, reading, rd_last, head_valid, head_dmrs, pop;

    assign last_in = {1'b0, N_sc} + ({5'd0, N_rb} * 12'd12) - 12'd1;
    assign cfg_bad = (N_rb == 7'd0) || (last_in >= TOTAL_SC_W) || (Sym_End < Sym_Start);

    assign head_valid = (occ_q != 2'd0);
    assign head_dmrs  = fd_q[rd_ptr_q];
    assign pop        = head_valid && Data_Ready;
    // occ_d is also the skid-buffer load seen by a read issued now, so a same-cycle pop frees a slot
    assign occ_d      = occ_q + {1'b0, inflight_q} - {1'b0, pop};
    assign reading    = (state_q == RD_DMRS) || (state_q == RD_DATA);

    always_comb begin
        rd_last = 1'b0;
        if (state_q == RD_DMRS) begin
            rd_last = ({1'b0, addr_q} == (last_q - 12'd1));
        end else if (state_q == RD_DATA) begin
            rd_last = ({1'b0, addr_q} == last_q);
        end
    end

    assign Rd_en   = reading && (occ_d < 2'd2);
    assign Rd_sym  = Rd_en ? sym_q : '0;
    assign Rd_addr = Rd_en ? addr_q : '0;

    always_ff @(posedge CLK_RE or negedge RST_RE) begin
        if (!RST_RE) begin
            state_q     <= IDLE;
            nsc_q       <= '0;
            last_q      <= '0;
            send_q      <= '0;
            addr_q      <= '0;
            sym_q       <= '0;
            inflight_q  <= 1'b0;
            infl_dmrs_q <= 1'b0;
            infl_last_q <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            inflight_q  <= Rd_en;
            infl_dmrs_q <= (state_q == RD_DMRS);
            infl_last_q <= rd_last;
            case (state_q)
                IDLE: begin
                    if (Start) begin
                        if (cfg_bad) begin
                            err_q  <= 1'b1;
                            done_q <= 1'b1;
                        end else begin
                            nsc_q  <= N_sc;
                            last_q <= last_in;
                            send_q <= Sym_End;
                            addr_q <= N_sc;
`ifdef RE_DEMAPPER_DMRS_OUT_EN
                            sym_q   <= Sym_Start;
                            state_q <= RD_DMRS;
`else
                            sym_q   <= Sym_Start + 4'd1;
                            state_q <= (Sym_End == Sym_Start) ? DRAIN : RD_DATA;
`endif
                        end
                    end
                end
                RD_DMRS: begin
                    if (Rd_en) begin
                        if (rd_last) begin
                            sym_q   <= sym_q + 4'd1;
                            addr_q  <= nsc_q;
                            state_q <= (send_q == sym_q) ? DRAIN : RD_DATA;
                        end else begin
                            addr_q <= addr_q + 11'd2;
                        end
                    end
                end
                RD_DATA: begin
                    if (Rd_en) begin
                        if (rd_last) begin
                            sym_q   <= sym_q + 4'd1;
                            addr_q  <= nsc_q;
                            state_q <= (send_q == sym_q) ? DRAIN : RD_DATA;
                        end else begin
                            addr_q <= addr_q + 11'd1;
                        end
                    end
                end
                DRAIN: begin
                    if (!head_valid && !inflight_q) begin
                        done_q  <= 1'b1;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Grid data arrives one cycle after Rd_en; the read-side throttle guarantees a free slot
    always_ff @(posedge CLK_RE or negedge RST_RE) begin
        if (!RST_RE) begin
            for (int unsigned i = 0; i < 2; i++) begin
                fi_q[i] <= '0;
                fq_q[i] <= '0;
                fd_q[i] <= 1'b0;
                fl_q[i] <= 1'b0;
            end
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            occ_q    <= '0;
        end else begin
            if (inflight_q) begin
                fi_q[wr_ptr_q] <= Rd_I;
                fq_q[wr_ptr_q] <= Rd_Q;
                fd_q[wr_ptr_q] <= infl_dmrs_q;
                fl_q[wr_ptr_q] <= infl_last_q;
                wr_ptr_q       <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            occ_q <= occ_d;
        end
    end

    assign Data_Valid = head_valid && !head_dmrs;
    assign Data_I     = Data_Valid ? fi_q[rd_ptr_q] : '0;
    assign Data_Q     = Data_Valid ? fq_q[rd_ptr_q] : '0;
`ifdef RE_DEMAPPER_DMRS_OUT_EN
    assign Dmrs_Valid = head_valid && head_dmrs;
    assign Dmrs_I     = Dmrs_Valid ? fi_q[rd_ptr_q] : '0;
    assign Dmrs_Q     = Dmrs_Valid ? fq_q[rd_ptr_q] : '0;
`else
    assign Dmrs_Valid = 1'b0;
    assign Dmrs_I     = '0;
    assign Dmrs_Q     = '0;
`endif
    assign Sym_Done   = pop && fl_q[rd_ptr_q];
    assign Busy       = (state_q != IDLE);
    assign DEM_Done   = done_q;
    assign Cfg_Err    = err_q;

endmodule

// File: tb/tb_re_demapper.sv
// Bench for re_demapper: grid emulator, queue-based RE model and one per-cycle compare process.
module tb_re_demapper;

    localparam int W = 18;
`ifdef RE_DEMAPPER_DMRS_OUT_EN
    localparam bit DMRS_EN = 1'b1;
`else
    localparam bit DMRS_EN = 1'b0;
`endif

    logic                CLK_RE = 1'b0;
    logic                RST_RE = 1'b0;
    logic                Start = 1'b0;
    logic [10:0]         N_sc = '0;
    logic [6:0]          N_rb = '0;
    logic [3:0]          Sym_Start = '0, Sym_End = '0;
    logic                Rd_en;
    logic [3:0]          Rd_sym;
    logic [10:0]         Rd_addr;
    logic signed [W-1:0] Rd_I = '0, Rd_Q = '0;
    logic signed [W-1:0] Data_I, Data_Q, Dmrs_I, Dmrs_Q;
    logic                Data_Valid, Dmrs_Valid, Busy, Sym_Done, DEM_Done, Cfg_Err;
    logic                Data_Ready = 1'b1;

    re_demapper #(.FFT_Len(W), .Total_Sc(1200)) dut (
        .CLK_RE(CLK_RE), .RST_RE(RST_RE), .Start(Start), .N_sc(N_sc), .N_rb(N_rb),
        .Sym_Start(Sym_Start), .Sym_End(Sym_End), .Rd_en(Rd_en), .Rd_sym(Rd_sym),
        .Rd_addr(Rd_addr), .Rd_I(Rd_I), .Rd_Q(Rd_Q), .Data_I(Data_I), .Data_Q(Data_Q),
        .Data_Valid(Data_Valid), .Data_Ready(Data_Ready), .Dmrs_I(Dmrs_I), .Dmrs_Q(Dmrs_Q),
        .Dmrs_Valid(Dmrs_Valid), .Busy(Busy), .Sym_Done(Sym_Done), .DEM_Done(DEM_Done),
        .Cfg_Err(Cfg_Err)
    );

    always #5 CLK_RE = ~CLK_RE;

    typedef struct {bit dmrs; int sym; int addr; bit last;} re_t;
    re_t exp_rd[$];
    re_t exp_out[$];

    int checks = 0, errors = 0;
    int job_cyc = 0;
    int n_rd, n_dmrs, n_data, n_symdone, n_demdone, n_err, err_cyc, first_valid;
    int reads_tot, pops_tot;
    longint first_I;
    bit busy1;

    function automatic logic signed [W-1:0] gI(int s, int a);
        return W'(s * 4096 + a);
    endfunction
    function automatic logic signed [W-1:0] gQ(int s, int a);
        return ~gI(s, a);
    endfunction

    task automatic chk(input string name, input longint got, input longint exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", name, got, exp);
        end
    endtask

    function automatic bit outs_nonzero();
        return Rd_en | (|Rd_sym) | (|Rd_addr) | (|Data_I) | (|Data_Q) | (|Dmrs_I) | (|Dmrs_Q)
             | Data_Valid | Dmrs_Valid | Busy | Sym_Done | DEM_Done | Cfg_Err;
    endfunction

    // Grid RAM: data for a read request appears one cycle later, junk otherwise
    initial begin
        bit req;
        int s, a;
        forever begin
            @(negedge CLK_RE);
            req = Rd_en; s = Rd_sym; a = Rd_addr;
            @(posedge CLK_RE);
            #1;
            Rd_I = req ? gI(s, a) : 18'sh2AAAA;
            Rd_Q = req ? gQ(s, a) : 18'sh15555;
        end
    end

    initial begin
        bit popped;
        re_t e;
        forever begin
            @(negedge CLK_RE);
            if (!RST_RE) begin
                chk("reset_outputs_zero", outs_nonzero(), 0);
            end else begin
                popped = (Data_Valid | Dmrs_Valid) & Data_Ready;
                chk("outstanding_le_2", (reads_tot + Rd_en - pops_tot - popped) <= 2, 1);
                if (Rd_en) begin
                    n_rd++; reads_tot++;
                    if (exp_rd.size() == 0) chk("rd_extra", 1, 0);
                    else begin
                        e = exp_rd.pop_front();
                        chk("rd_sym", Rd_sym, e.sym);
                        chk("rd_addr", Rd_addr, e.addr);
                    end
                end else begin
                    chk("rd_idle_zero", {Rd_sym, Rd_addr}, 0);
                end
                chk("both_valid", Data_Valid & Dmrs_Valid, 0);
                if (Data_Valid | Dmrs_Valid) begin
                    if (first_valid < 0) begin
                        first_valid = job_cyc;
                        first_I = Data_Valid ? Data_I : Dmrs_I;
                    end
                    if (exp_out.size() == 0) chk("out_extra", 1, 0);
                    else begin
                        e = exp_out[0];
                        chk("out_kind_dmrs", Dmrs_Valid, e.dmrs);
                        chk("out_I", Data_Valid ? Data_I : Dmrs_I, gI(e.sym, e.addr));
                        chk("out_Q", Data_Valid ? Data_Q : Dmrs_Q, gQ(e.sym, e.addr));
                        if (popped) begin
                            void'(exp_out.pop_front());
                            chk("sym_done_on_pop", Sym_Done, e.last);
                            if (e.dmrs) n_dmrs++; else n_data++;
                        end
                    end
                end
                if (popped) pops_tot++;
                else chk("sym_done_no_pop", Sym_Done, 0);
                if (!Data_Valid) chk("data_idle_zero", (Data_I != 0) || (Data_Q != 0), 0);
                if (!Dmrs_Valid) chk("dmrs_idle_zero", (Dmrs_I != 0) || (Dmrs_Q != 0), 0);
                if (Sym_Done) n_symdone++;
                if (DEM_Done) n_demdone++;
                if (Cfg_Err) begin n_err++; err_cyc = job_cyc; end
                if (job_cyc == 1) busy1 = Busy;
            end
            job_cyc++;
        end
    end

    task automatic build(input int nsc, input int nrb, input int ss, input int se);
        int li;
        li = nsc + 12 * nrb - 1;
        exp_rd.delete();
        exp_out.delete();
        if (DMRS_EN)
            for (int a = nsc; a < li; a += 2) begin
                exp_rd.push_back('{1'b1, ss, a, a == li - 1});
                exp_out.push_back('{1'b1, ss, a, a == li - 1});
            end
        for (int s = ss + 1; s <= se; s++)
            for (int a = nsc; a <= li; a++) begin
                exp_rd.push_back('{1'b0, s, a, a == li});
                exp_out.push_back('{1'b0, s, a, a == li});
            end
    endtask

    // mode: 0 ready high, 1 ready random, 2 ready low for cycles 8..17
    task automatic run_job(input int nsc, input int nrb, input int ss, input int se,
                           input int mode, input int abort_at, input bit glitch);
        bit bad;
        int li, rd_snap;
        li  = nsc + 12 * nrb - 1;
        bad = (nrb == 0) || (li >= 1200) || (se < ss);
        if (bad) begin exp_rd.delete(); exp_out.delete(); end
        else build(nsc, nrb, ss, se);
        n_rd = 0; n_dmrs = 0; n_data = 0; n_symdone = 0; n_demdone = 0; n_err = 0;
        err_cyc = -1; first_valid = -1; first_I = 0; busy1 = 0; reads_tot = 0; pops_tot = 0;
        @(posedge CLK_RE); #1;
        Start = 1'b1; N_sc = 11'(nsc); N_rb = 7'(nrb); Sym_Start = 4'(ss); Sym_End = 4'(se);
        Data_Ready = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
        job_cyc = 0;
        for (int c = 1; c < 3000 && n_demdone == 0; c++) begin
            @(posedge CLK_RE); #1;
            Start = glitch && (c == 20);
            if (glitch && c == 20) begin
                N_sc = 11'd0; N_rb = 7'd1; Sym_Start = 4'd0; Sym_End = 4'd0;
            end
            case (mode)
                1:       Data_Ready = 1'($urandom_range(0, 1));
                2:       Data_Ready = !(c >= 8 && c <= 17);
                default: Data_Ready = 1'b1;
            endcase
            if (mode == 2 && c == 12) rd_snap = n_rd;
            if (mode == 2 && c == 18) chk("stall_no_reads", n_rd, rd_snap);
            if (abort_at > 0 && c == abort_at) begin
                RST_RE = 1'b0;
                #1;
                chk("abort_outputs_zero", outs_nonzero(), 0);
                exp_rd.delete(); exp_out.delete();
                repeat (2) @(posedge CLK_RE);
                #1;
                RST_RE = 1'b1; Data_Ready = 1'b1; Start = 1'b0;
                n_demdone = 0; n_rd = 0; reads_tot = 0; pops_tot = 0;
                repeat (20) @(posedge CLK_RE);
                chk("abort_no_dem_done", n_demdone, 0);
                chk("abort_no_reads", n_rd, 0);
                return;
            end
        end
        Start = 1'b0;
        Data_Ready = 1'b1;
        repeat (4) @(posedge CLK_RE);
        #1;
        chk("dem_done_once", n_demdone, 1);
        chk("busy_after_done", Busy, 0);
        if (bad) begin
            chk("cfg_err_count", n_err, 1);
            chk("cfg_err_cycle", err_cyc, 1);
            chk("cfg_err_no_reads", n_rd, 0);
        end else begin
            chk("cfg_err_none", n_err, 0);
            chk("reads_left", exp_rd.size(), 0);
            chk("outputs_left", exp_out.size(), 0);
            chk("dmrs_count", n_dmrs, DMRS_EN ? 6 * nrb : 0);
            chk("data_count", n_data, 12 * nrb * (se - ss));
            chk("sym_done_count", n_symdone, int'(DMRS_EN) + (se - ss));
            chk("busy_cycle1", busy1, 1);
            if (mode == 0 && (DMRS_EN || se > ss)) chk("first_valid_cycle", first_valid, 3);
        end
    endtask

    initial begin
        n_demdone = 0; first_valid = -1; reads_tot = 0; pops_tot = 0;
        repeat (3) @(posedge CLK_RE);
        #1;
        chk("reset_state", outs_nonzero(), 0);
        RST_RE = 1'b1;
        repeat (2) @(posedge CLK_RE);

        run_job(0, 1, 2, 3, 0, 0, 1'b0);
        chk("t1_first_I", first_I, DMRS_EN ? 8192 : 12288);
        chk("t1_data_res", n_data, 12);
        chk("t1_sym_done", n_symdone, DMRS_EN ? 2 : 1);

        run_job(1188, 1, 0, 1, 0, 0, 1'b0);
        run_job(1189, 1, 0, 1, 0, 0, 1'b0);
        chk("t3_cfg_err_literal", n_err, 1);
        run_job(10, 0, 0, 1, 0, 0, 1'b0);
        run_job(10, 1, 4, 3, 0, 0, 1'b0);

        run_job(100, 2, 0, 4, 1, 0, 1'b1);
        chk("t6_data_res", n_data, 96);

        run_job(0, 2, 0, 1, 2, 0, 1'b0);

        run_job(100, 2, 0, 4, 0, 40, 1'b0);
        run_job(100, 2, 0, 4, 0, 0, 1'b0);

        run_job(0, 1, 5, 5, 0, 0, 1'b0);
        chk("t10_reads", n_rd, DMRS_EN ? 6 : 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
